// File: rtl/toy_bpu_btb_entry_buffer_pkg.sv
// Shared types and sizes for the BTB entry buffer between BP decode and the BTB.
package toy_bpu_btb_entry_buffer_pkg;

  localparam int unsigned ENTRY_BUFFER_NUM       = 8;
  localparam int unsigned ENTRY_BUFFER_PTR_WIDTH = 3;
  localparam int unsigned BTB_INDEX_WIDTH        = 6;
  localparam int unsigned BTB_TAG_WIDTH          = 8;
  localparam int unsigned BTB_WAY_WIDTH          = 2;
  localparam int unsigned BTB_ENTRY_WIDTH        = 32;

  typedef struct packed {
    logic [BTB_INDEX_WIDTH-1:0] index;
    logic [BTB_TAG_WIDTH-1:0]   tag;
    logic [BTB_WAY_WIDTH-1:0]   way_hit;
    logic                       real_taken;
    logic [BTB_ENTRY_WIDTH-1:0] entry;
  } btb_entry_buffer_pkg;

  localparam int unsigned BTB_ENTRY_BUFFER_PLD_WIDTH = $bits(btb_entry_buffer_pkg);

endpackage

// File: rtl/cmn_onehot_to_bin.sv
// Encodes a one-hot (or all-zero) vector to the binary index of its set bit.
module cmn_onehot_to_bin #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] onehot,
  output logic [W-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (onehot[i]) bin = bin | W'(i);
    end
  end

endmodule

// File: rtl/cmn_real_mux_onehot.sv
// AND-OR multiplexer driven by a one-hot select; all-zero select yields zero.
module cmn_real_mux_onehot #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic [N-1:0]        sel,
  input  logic [N-1:0][W-1:0] din,
  output logic [W-1:0]        dout
);

  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < N; i++) begin
      dout = dout | (din[i] & {W{sel[i]}});
    end
  end

endmodule

// File: rtl/toy_bpu_btb_entry_buffer.sv
// Circular buffer of pending BTB updates with in-place merging and full bypass visibility.
module toy_bpu_btb_entry_buffer
  import toy_bpu_btb_entry_buffer_pkg::*;
(
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       alloc_vld,
  output logic                                       alloc_rdy,
  input  btb_entry_buffer_pkg                        alloc_pld,
  input  logic                                       btb_update_vld,
  output logic                                       btb_update_rdy,
  output btb_entry_buffer_pkg                        btb_update_pld,
  output btb_entry_buffer_pkg [ENTRY_BUFFER_NUM-1:0] entry_buffer_pld,
  output logic [ENTRY_BUFFER_PTR_WIDTH:0]            entry_buffer_ptr,
  output logic [ENTRY_BUFFER_NUM-1:0]                entry_buffer_ena
);

  localparam int unsigned N     = ENTRY_BUFFER_NUM;
  localparam int unsigned IW    = ENTRY_BUFFER_PTR_WIDTH;
  localparam int unsigned PW    = ENTRY_BUFFER_PTR_WIDTH + 1;
  localparam int unsigned PLD_W = BTB_ENTRY_BUFFER_PLD_WIDTH;

  btb_entry_buffer_pkg [N-1:0] slot_q, slot_d;
  logic [N-1:0]                ena_q, ena_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;

  logic [IW-1:0]               wr_idx, rd_idx, hit_idx;
  logic                        empty, full, pop;
  logic [N-1:0]                hit_vec, rd_sel;
  logic                        merge_hit, merge_push, new_push;
  logic [N-1:0][PLD_W-1:0]     slot_bits;
  logic [PLD_W-1:0]            head_bits;

  assign wr_idx = wr_ptr_q[IW-1:0];
  assign rd_idx = rd_ptr_q[IW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
  assign pop    = btb_update_vld && !empty;

  // Merge candidates: live slots matching index+tag, never the head leaving this cycle.
  always_comb begin
    hit_vec = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hit_vec[i] = alloc_vld && ena_q[i]
                   && (slot_q[i].index == alloc_pld.index)
                   && (slot_q[i].tag == alloc_pld.tag)
                   && !(pop && (rd_idx == IW'(i)));
    end
  end

  assign merge_hit  = |hit_vec;
  assign merge_push = merge_hit;
  assign new_push   = alloc_vld && !full && !merge_hit;

  cmn_onehot_to_bin #(
    .N (N),
    .W (IW)
  ) u_hit_enc (
    .onehot (hit_vec),
    .bin    (hit_idx)
  );

  assign rd_sel    = {{(N-1){1'b0}}, 1'b1} << rd_idx;
  assign slot_bits = slot_q;

  cmn_real_mux_onehot #(
    .N (N),
    .W (PLD_W)
  ) u_head_mux (
    .sel  (rd_sel),
    .din  (slot_bits),
    .dout (head_bits)
  );

  // Next-state: pop frees the head, merge rewrites in place, new push appends at wr_ptr.
  always_comb begin
    slot_d   = slot_q;
    ena_d    = ena_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      ena_d[rd_idx] = 1'b0;
      rd_ptr_d      = rd_ptr_q + PW'(1);
    end
    if (merge_push) begin
      slot_d[hit_idx] = alloc_pld;
    end
    if (new_push) begin
      slot_d[wr_idx] = alloc_pld;
      ena_d[wr_idx]  = 1'b1;
      wr_ptr_d       = wr_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= '0;
      ena_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      slot_q   <= slot_d;
      ena_q    <= ena_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign alloc_rdy        = !full || merge_hit;
  assign btb_update_rdy   = pop;
  assign btb_update_pld   = btb_entry_buffer_pkg'(head_bits);
  assign entry_buffer_pld = slot_q;
  assign entry_buffer_ptr = wr_ptr_q;
  assign entry_buffer_ena = ena_q;

endmodule
